// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: FSM states and the store/load
// size codes produced by the core's controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Store size codes (cpu_memwrite)
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_B    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_W    = 2'b11;

  // Load size codes (cpu_sizeload); 3'b11x is not a valid load
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  // True when a load code is one the bridge can execute (or is "no load")
  function automatic logic ld_code_legal(input logic [2:0] code);
    return code[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Valid/ready data bus between the bridge (master) and the memory system (slave).
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        we;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output addr, wdata, wstrb, we, valid,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, wstrb, we, valid,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane logic for the bridge, purely combinational: store data replication
// and strobes, access legality, and load extraction with sign/zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  // store / request side (straight from the core)
  input  logic [1:0]  memwrite,
  input  logic [2:0]  sizeload,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic        illegal,
  // load side (registered request, raw bus word)
  input  logic [2:0]  ld_code,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  assign ld_shifted = ld_word >> {ld_offset, 3'b000};

  // Replicate store data onto every lane it may land in and enable only the addressed bytes
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    lane_wdata = '0;
    lane_wstrb = 4'b0000;
    case (memwrite)
      MW_B: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << offset;
      end
      MW_H: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = offset[1] ? 4'b1100 : 4'b0011;
      end
      MW_W: begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Reject mixed load+store, unknown load codes and misaligned halfword/word accesses
  always_comb begin
    illegal = 1'b0;
    if ((memwrite != MW_NONE) && (sizeload != LD_NONE))
      illegal = 1'b1;
    if (!ld_code_legal(sizeload))
      illegal = 1'b1;
    if (((memwrite == MW_H) || (sizeload == LD_H) || (sizeload == LD_HU)) && offset[0])
      illegal = 1'b1;
    if (((memwrite == MW_W) || (sizeload == LD_W)) && (offset != 2'b00))
      illegal = 1'b1;
  end

  // Pull the addressed bytes down to bit 0 and extend to 32 bits
  always_comb begin
    ld_data = '0;
    case (ld_code)
      LD_B:    ld_data = {{24{ld_shifted[7]}},  ld_shifted[7:0]};
      LD_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LD_W:    ld_data = ld_shifted;
      LD_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      LD_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Load/store bridge: turns one core data access into one valid/ready bus
// transaction, stalls the core until it completes, and reports faults for
// illegal accesses and bus timeouts.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_memwrite,
  input  logic [2:0]  cpu_sizeload,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  dmem_if.master      bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic          we_q, fault_q;
  logic [2:0]    ld_code_q;
  logic [1:0]    ld_off_q;

  logic          access;
  logic          accept;     // legal request latched in IDLE
  logic          go_fault;   // entering DONE with a fault
  logic          to_resp;    // load request accepted on the bus
  logic          capture;    // read data arrived
  logic          cnt_inc;

  logic [31:0]   lane_wdata, ld_data;
  logic [3:0]    lane_wstrb;
  logic          illegal;

  assign access = (cpu_memwrite != MW_NONE) || (cpu_sizeload != LD_NONE);

  dmem_lane u_lane (
    .memwrite   (cpu_memwrite),
    .sizeload   (cpu_sizeload),
    .offset     (cpu_addr[1:0]),
    .store_data (cpu_wdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .illegal    (illegal),
    .ld_code    (ld_code_q),
    .ld_offset  (ld_off_q),
    .ld_word    (bus.rdata),
    .ld_data    (ld_data)
  );

  // Next-state and per-cycle control decisions
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    go_fault = 1'b0;
    to_resp  = 1'b0;
    capture  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = (illegal) ? DONE : REQ;
          accept  = !illegal;
          go_fault = illegal;
        end
      end
      REQ: begin
        if (bus.ready) begin
          state_d = we_q ? DONE : RESP;
          to_resp = !we_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          go_fault = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (bus.rvalid) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          go_fault = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Wait counter, restarted at the start of each bus phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt_q <= '0;
    else if (accept || to_resp) cnt_q <= '0;
    else if (cnt_inc)           cnt_q <= cnt_q + 1'b1;
  end

  // Request registers: hold the bus fields stable for the whole REQ phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      ld_code_q <= LD_NONE;
      ld_off_q  <= 2'b00;
    end else if (accept) begin
      addr_q    <= {cpu_addr[31:2], 2'b00};
      wdata_q   <= lane_wdata;
      wstrb_q   <= lane_wstrb;
      we_q      <= (cpu_memwrite != MW_NONE);
      ld_code_q <= cpu_sizeload;
      ld_off_q  <= cpu_addr[1:0];
    end
  end

  // Result registers: load data and the fault flag presented in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept || go_fault) begin
        rdata_q <= '0;
        fault_q <= go_fault;
      end
      if (capture)
        rdata_q <= ld_data;
    end
  end

  // Core-facing outputs; stall is forced low while reset is held so a pending request never stalls a reset core
  always_comb begin
    cpu_stall = reset && (((state_q == IDLE) && access) || (state_q == REQ) || (state_q == RESP));
    cpu_fault = (state_q == DONE) && fault_q;
    cpu_rdata = (state_q == DONE) ? rdata_q : '0;
  end

  assign bus.valid = (state_q == REQ);
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;
  assign bus.we    = we_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// accesses, all checked against a byte-level reference model.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_memwrite;
  logic [2:0]  cpu_sizeload;
  logic        cpu_stall, cpu_fault;

  int n_run  = 0;
  int n_fail = 0;
  bit in_done = 1'b0;

  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memwrite (cpu_memwrite),
    .cpu_sizeload (cpu_sizeload),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_fault    (cpu_fault),
    .bus          (bus)
  );

  // ---------------- reference model ----------------
  function automatic int store_size(input logic [1:0] mw);
    case (mw)
      2'd1: return 1;
      2'd2: return 2;
      2'd3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int load_size(input logic [2:0] sl);
    case (sl)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [1:0] mw, input logic [2:0] sl, input logic [31:0] a);
    int sz;
    if (mw != 0 && sl != 0) return 1'b1;
    if (sl >= 6) return 1'b1;
    sz = (mw != 0) ? store_size(mw) : load_size(sl);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] mw, input logic [31:0] a);
    int sz = store_size(mw);
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] mw, input logic [31:0] wd);
    logic [31:0] r = '0;
    int sz = store_size(mw);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sl, input logic [31:0] a,
                                             input logic [31:0] word);
    int sz = load_size(sl);
    longint v, m;
    v = longint'({32'h0, word}) >>> (8 * int'(a[1:0]));
    m = longint'(1) << (8 * sz);
    v = v % m;
    if ((sl == 3'd1 || sl == 3'd2) && v >= (m / 2)) v = v - m;
    return v[31:0];
  endfunction

  // ---------------- one complete access with a scripted bus slave ----------------
  task automatic access(input string name, input logic [1:0] mw, input logic [2:0] sl,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int ready_dly, input int rvalid_dly,
                        input bit ready_never, input bit rvalid_never);
    bit bad, store, exp_fault, done, hs_seen, hs_now;
    int exp_stalls, exp_vcyc, stalls, vcyc, k;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_wstrb;

    bad       = model_illegal(mw, sl, a);
    store     = (mw != 0);
    exp_wstrb = store ? model_wstrb(mw, a) : 4'b0000;
    exp_wdata = store ? model_wdata(mw, wd) : 32'h0;
    exp_rdata = 32'h0;
    exp_fault = 1'b0;
    if (bad) begin
      exp_vcyc = 0; exp_stalls = 1; exp_fault = 1'b1;
    end else if (ready_never) begin
      exp_vcyc = TIMEOUT; exp_stalls = 1 + TIMEOUT; exp_fault = 1'b1;
    end else if (store) begin
      exp_vcyc = ready_dly + 1; exp_stalls = 1 + exp_vcyc;
    end else if (rvalid_never) begin
      exp_vcyc = ready_dly + 1; exp_stalls = 1 + exp_vcyc + TIMEOUT; exp_fault = 1'b1;
    end else begin
      exp_vcyc = ready_dly + 1; exp_stalls = 1 + exp_vcyc + rvalid_dly;
      exp_rdata = model_load(sl, a, word);
    end

    cpu_addr = a; cpu_wdata = wd; cpu_memwrite = mw; cpu_sizeload = sl;
    #1;
    if (in_done) begin
      @(negedge clk);
      #1;
    end
    in_done = 1'b0;
    stalls = 0; vcyc = 0; k = 0; hs_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (bus.valid) begin
        vcyc++;
        n_run++;
        if ({bus.addr, bus.we, bus.wstrb} !== {a[31:2], 2'b00, store, exp_wstrb}) begin
          n_fail++;
          $display("FAIL %s req_fields: addr=%h we=%b wstrb=%b expected addr=%h we=%b wstrb=%b",
                   name, bus.addr, bus.we, bus.wstrb, {a[31:2], 2'b00}, store, exp_wstrb);
        end
        if (store) begin
          n_run++;
          if (bus.wdata !== exp_wdata) begin
            n_fail++;
            $display("FAIL %s wdata: got %h expected %h", name, bus.wdata, exp_wdata);
          end
        end
      end
      bus.ready = bus.valid && !ready_never && (vcyc > ready_dly);
      if (hs_seen) begin
        k++;
        bus.rvalid = !rvalid_never && (k >= rvalid_dly);
      end else begin
        bus.rvalid = 1'b0;
      end
      bus.rdata = bus.rvalid ? word : $urandom;
      hs_now = bus.valid && bus.ready;
      @(posedge clk);
      if (hs_now) hs_seen = 1'b1;
      @(negedge clk);
      #1;
    end

    n_run++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s done: still stalled after 200 cycles, expected completion", name);
    end
    n_run++;
    if (stalls != exp_stalls) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
    end
    n_run++;
    if (vcyc != exp_vcyc) begin
      n_fail++;
      $display("FAIL %s valid_cycles: got %0d expected %0d", name, vcyc, exp_vcyc);
    end
    n_run++;
    if ({cpu_fault, cpu_rdata, bus.valid} !== {exp_fault, exp_rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL %s done_result: fault=%b rdata=%h valid=%b expected fault=%b rdata=%h valid=0",
               name, cpu_fault, cpu_rdata, bus.valid, exp_fault, exp_rdata);
    end
    cpu_memwrite = MW_NONE; cpu_sizeload = LD_NONE;
    bus.ready = 1'b0; bus.rvalid = 1'b0;
    in_done = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      in_done = 1'b0;
      n_run++;
      if ({cpu_stall, cpu_fault, bus.valid, cpu_rdata} !== 35'h0) begin
        n_fail++;
        $display("FAIL idle: stall=%b fault=%b valid=%b rdata=%h expected all 0",
                 cpu_stall, cpu_fault, bus.valid, cpu_rdata);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_memwrite = MW_NONE; cpu_sizeload = LD_NONE;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_run++;
    if ({cpu_stall, cpu_fault, cpu_rdata, bus.valid, bus.we, bus.wstrb, bus.addr} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b fault=%b rdata=%h valid=%b we=%b wstrb=%b addr=%h expected all 0",
               cpu_stall, cpu_fault, cpu_rdata, bus.valid, bus.we, bus.wstrb, bus.addr);
    end
    cpu_memwrite = MW_W;
    #1;
    n_run++;
    if ({cpu_stall, bus.valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_with_request: stall=%b valid=%b expected 0 0", cpu_stall, bus.valid);
    end
    @(negedge clk);
    @(posedge clk);
    n_run++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b expected 0", bus.valid);
    end
    cpu_memwrite = MW_NONE;
    @(negedge clk);
    #1;
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_store_lanes;
    access("sw_100", MW_W, LD_NONE, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("sb_103", MW_B, LD_NONE, 32'h103, 32'h000000A5, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("sh_102", MW_H, LD_NONE, 32'h102, 32'h1234BEEF, 32'h0, 2, 1, 1'b0, 1'b0);
    idle(1);
    access("sb_001", MW_B, LD_NONE, 32'h201, 32'hFFFFFF3C, 32'h0, 1, 1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_load_extend;
    access("lb_102",  MW_NONE, LD_B,  32'h102, 32'h0, 32'h0080FF00, 0, 2, 1'b0, 1'b0);
    idle(1);
    access("lbu_102", MW_NONE, LD_BU, 32'h102, 32'h0, 32'h0080FF00, 0, 2, 1'b0, 1'b0);
    idle(1);
    access("lh_102",  MW_NONE, LD_H,  32'h102, 32'h0, 32'h80011234, 1, 1, 1'b0, 1'b0);
    idle(1);
    access("lhu_102", MW_NONE, LD_HU, 32'h102, 32'h0, 32'h80011234, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("lw_400",  MW_NONE, LD_W,  32'h400, 32'h0, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_illegal;
    access("lh_mis",  MW_NONE, LD_H,    32'h101, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("sb_lw",   MW_B,    LD_W,    32'h100, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("ld_110",  MW_NONE, 3'b110,  32'h100, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
    access("sw_mis",  MW_W,    LD_NONE, 32'h102, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_timeout;
    access("lw_noready",  MW_NONE, LD_W, 32'h500, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0);
    idle(2);
    access("lw_norvalid", MW_NONE, LD_W, 32'h504, 32'h0, 32'h12345678, 1, 1, 1'b0, 1'b1);
    idle(2);
    access("sb_noready",  MW_B, LD_NONE, 32'h509, 32'h77, 32'h0, 0, 1, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid_req;
    cpu_addr = 32'h200; cpu_wdata = 32'h12345678; cpu_memwrite = MW_W; cpu_sizeload = LD_NONE;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_run++;
    if (bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req_valid: valid=%b expected 1", bus.valid);
    end
    #1;
    reset = 1'b0;
    #1;
    n_run++;
    if ({bus.valid, cpu_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_req_reset: valid=%b stall=%b expected 0 0", bus.valid, cpu_stall);
    end
    @(negedge clk);
    #1;
    cpu_memwrite = MW_NONE;
    @(negedge clk);
    #2;
    reset = 1'b1;
    idle(2);
    access("sw_after_rst", MW_W, LD_NONE, 32'h300, 32'h0BADF00D, 32'h0, 0, 1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back;
    access("b2b_sw", MW_W, LD_NONE, 32'h600, 32'h11223344, 32'h0, 0, 1, 1'b0, 1'b0);
    access("b2b_lw", MW_NONE, LD_W, 32'h600, 32'h0, 32'h11223344, 0, 1, 1'b0, 1'b0);
    access("b2b_sb", MW_B, LD_NONE, 32'h602, 32'h99, 32'h0, 1, 1, 1'b0, 1'b0);
    access("b2b_lb", MW_NONE, LD_B, 32'h603, 32'h0, 32'hF0FFFFFF, 0, 3, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [1:0]  mw;
      logic [2:0]  sl;
      logic [31:0] a;
      int kind, sz;
      kind = $urandom_range(0, 9);
      a = $urandom;
      mw = MW_NONE;
      sl = LD_NONE;
      if (kind < 4) begin
        mw = 2'($urandom_range(1, 3));
        sz = store_size(mw);
        a = a & ~(32'(sz) - 32'd1);
      end else if (kind < 8) begin
        sl = 3'($urandom_range(1, 5));
        sz = load_size(sl);
        a = a & ~(32'(sz) - 32'd1);
      end else begin
        mw = 2'($urandom_range(0, 3));
        sl = 3'($urandom_range(0, 7));
        if (mw == 0 && sl == 0) sl = 3'b111;
      end
      access($sformatf("rand%0d", it), mw, sl, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_store_lanes;
    test_load_extend;
    test_illegal;
    test_timeout;
    test_reset_mid_req;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
